// File: rtl/fpu_normalize_round.sv
// Normalise, round-to-nearest-even and pack a raw FPU adder result.
// Ports: clk/reset_n; in_* raw operand (valid/ready); out_* packed result + flags.
module fpu_normalize_round (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [26:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_zero
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        sign_q;
  logic [9:0]  exp_q;
  logic [26:0] mant_q;
  logic        zero_q;
  logic        unf_q;

  logic [31:0] result_q;
  logic        ovf_o;
  logic        unf_o;
  logic        zero_o;

  logic        accept;
  logic [9:0]  exp_in;

  logic        mant_nz;
  logic        exp_gt1;
  logic        n_zero;
  logic        n_carry;
  logic        n_lsh;
  logic        n_flush;
  logic        n_ok;

  logic        round_up;
  logic [23:0] frac_sum;
  logic        rnd_carry;
  logic [9:0]  exp_rnd;
  logic        ovf_rnd;
  logic [31:0] res_rnd;

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign out_result    = result_q;
  assign out_overflow  = ovf_o;
  assign out_underflow = unf_o;
  assign out_zero      = zero_o;

  assign accept = in_valid & in_ready;

  // A zero exponent with a nonzero mantissa is a denormal-range
  // value; it shares the exponent of the smallest normal.
  assign exp_in = ((in_exp == 8'd0) && (|in_mant))
                ? 10'd1
                : {2'b00, in_exp};

  // Normalisation rules, made mutually exclusive so the
  // first-match priority is encoded in the terms themselves.
  assign mant_nz = |mant_q;
  assign exp_gt1 = (exp_q > 10'd1);
  assign n_zero  = ~mant_nz;
  assign n_carry = mant_nz & mant_q[26];
  assign n_lsh   = mant_nz & ~mant_q[26]
                 & ~mant_q[25] & exp_gt1;
  assign n_flush = mant_nz & ~mant_q[26]
                 & ~mant_q[25] & ~exp_gt1;
  assign n_ok    = mant_nz & ~mant_q[26] & mant_q[25];

  // Hidden bit is 1 whenever a nonzero result reaches ROUND, so
  // incrementing the fraction alone and watching its carry is
  // equivalent to incrementing the full significand.
  assign round_up  = mant_q[1] & (mant_q[0] | mant_q[2]);
  assign frac_sum  = {1'b0, mant_q[24:2]} + 24'(round_up);
  assign rnd_carry = frac_sum[23];
  assign exp_rnd   = exp_q + 10'(rnd_carry);
  assign ovf_rnd   = ~zero_q & (exp_rnd >= 10'd255);

  always_comb begin
    res_rnd = {sign_q, exp_rnd[7:0], frac_sum[22:0]};
    if (zero_q) begin
      res_rnd = {sign_q, 31'h0};
    end else if (ovf_rnd) begin
      res_rnd = {sign_q, 8'hFF, 23'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = NORM;
      end
      NORM: begin
        if (n_zero | n_flush | n_ok) state_nxt = ROUND;
      end
      ROUND: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sign_q   <= 1'b0;
      exp_q    <= 10'd0;
      mant_q   <= 27'd0;
      zero_q   <= 1'b0;
      unf_q    <= 1'b0;
      result_q <= 32'h0;
      ovf_o    <= 1'b0;
      unf_o    <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= in_sign;
            exp_q  <= exp_in;
            mant_q <= in_mant;
            zero_q <= 1'b0;
            unf_q  <= 1'b0;
            ovf_o  <= 1'b0;
            unf_o  <= 1'b0;
            zero_o <= 1'b0;
          end
        end
        NORM: begin
          unique case (1'b1)
            n_zero: begin
              zero_q <= 1'b1;
            end
            n_carry: begin
              // Shift right, folding the dropped bit into sticky.
              mant_q <= {1'b0, mant_q[26:2],
                         mant_q[1] | mant_q[0]};
              exp_q  <= exp_q + 10'd1;
            end
            n_lsh: begin
              mant_q <= {mant_q[25:0], 1'b0};
              exp_q  <= exp_q - 10'd1;
            end
            n_flush: begin
              zero_q <= 1'b1;
              unf_q  <= 1'b1;
            end
            n_ok: begin
              mant_q <= mant_q;
            end
            default: begin
              mant_q <= mant_q;
            end
          endcase
        end
        ROUND: begin
          result_q <= res_rnd;
          ovf_o    <= ovf_rnd;
          unf_o    <= unf_q;
          zero_o   <= zero_q;
        end
        DONE: begin
          result_q <= result_q;
        end
        default: begin
          result_q <= result_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Directed bench for fpu_normalize_round: hand-computed vectors,
// latency, backpressure and mid-operation reset.
module tb_fpu_normalize_round;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_zero;

  int errors = 0;
  int checks = 0;

  fpu_normalize_round dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_zero     (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in DONE.
  task automatic run_op(input string tag,
                        input logic s,
                        input logic [7:0] e,
                        input logic [26:0] m,
                        input logic [31:0] r,
                        input logic ov,
                        input logic un,
                        input logic zr,
                        input int lat);
    int cnt;
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_mant  = 27'h5A5A5A5;
    in_exp   = 8'h33;
    check({tag, ".busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && cnt < 64) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check({tag, ".vld"}, 32'(out_valid), 32'd1);
    check({tag, ".lat"}, 32'(cnt), 32'(lat));
    check({tag, ".res"}, out_result, r);
    check({tag, ".ovf"}, 32'(out_overflow), 32'(ov));
    check({tag, ".unf"}, 32'(out_underflow), 32'(un));
    check({tag, ".zero"}, 32'(out_zero), 32'(zr));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] held;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 27'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst.vld", 32'(out_valid), 32'd0);
    check("rst.res", out_result, 32'h0);
    check("rst.rdy", 32'(in_ready), 32'd1);
    check("rst.flags",
          {29'd0, out_overflow, out_underflow, out_zero},
          32'd0);

    run_op("norm", 0, 8'd127, 27'h2000000,
           32'h3F800000, 0, 0, 0, 3);
    consume();
    run_op("carry", 0, 8'd127, 27'h4000000,
           32'h40000000, 0, 0, 0, 4);
    consume();
    run_op("lsh2", 0, 8'd130, 27'h0800000,
           32'h40000000, 0, 0, 0, 5);
    consume();
    run_op("tie_up", 0, 8'd127, 27'h2000006,
           32'h3F800002, 0, 0, 0, 3);
    consume();
    run_op("tie_even", 0, 8'd127, 27'h2000002,
           32'h3F800000, 0, 0, 0, 3);
    consume();
    run_op("rnd_carry", 1, 8'd127, 27'h3FFFFFE,
           32'hC0000000, 0, 0, 0, 3);
    consume();
    run_op("ovf", 0, 8'd254, 27'h4000000,
           32'h7F800000, 1, 0, 0, 4);
    consume();
    run_op("zero", 1, 8'd100, 27'h0,
           32'h80000000, 0, 0, 1, 3);
    consume();
    run_op("unf", 0, 8'd1, 27'h1000000,
           32'h00000000, 0, 1, 1, 3);
    consume();
    run_op("exp0", 0, 8'd0, 27'h2000000,
           32'h00800000, 0, 0, 0, 3);
    consume();

    out_ready = 1'b0;
    run_op("bp", 0, 8'd128, 27'h2C00000,
           32'h40300000, 0, 0, 0, 3);
    held = out_result;
    in_valid = 1'b1;
    in_exp   = 8'd3;
    in_mant  = 27'h2000000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp.hold", out_result, held);
      check("bp.vld", 32'(out_valid), 32'd1);
      check("bp.rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume();
    check("bp.idle", 32'(out_valid), 32'd0);
    run_op("bp_next", 0, 8'd127, 27'h2000000,
           32'h3F800000, 0, 0, 0, 3);
    consume();

    run_op("pre_rst", 0, 8'd254, 27'h4000000,
           32'h7F800000, 1, 0, 0, 4);
    consume();
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'd130;
    in_mant  = 27'h0800000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("mid.vld", 32'(out_valid), 32'd0);
    check("mid.res", out_result, 32'h0);
    check("mid.flags",
          {29'd0, out_overflow, out_underflow, out_zero},
          32'd0);
    check("mid.rdy", 32'(in_ready), 32'd1);
    run_op("post_rst", 0, 8'd130, 27'h0800000,
           32'h40000000, 0, 0, 0, 5);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
